// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_pkg                                                   |
// | Description : Shared constants, FSM encoding and frame helpers for the   |
// |               configurable UART transmitter.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int frame_clks(input int data_bits, input int parity,
                                    input int stop_bits, input int cpb);
    return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * cpb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                               |
// | Description : Synchronous FIFO with wrap-bit pointers feeding the UART.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra MSB distinguishes a full FIFO from an empty one with equal indices.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign level     = r_wr_ptr - r_rd_ptr;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_cfg                                                |
// | Description : Buffered UART transmitter, configurable width/parity/stop. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;

  tx_state_t            r_state, w_state_next;
  logic [CW-1:0]        r_clk_cnt, w_clk_cnt_next;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_next;
  logic                 r_par, w_par_next;
  logic                 r_txd, w_txd_next;
  logic                 w_bit_end;
  logic                 w_pop;
  logic                 w_done;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (w_pop),
    .rdata (w_fifo_data),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign tx_ready = !w_full;
  assign tx_busy  = (r_state != ST_IDLE);
  assign tx_done  = w_done;
  assign txd      = r_txd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shreg   <= w_shreg_next;
      r_par     <= w_par_next;
      r_txd     <= w_txd_next;
    end
  end

  always_comb begin
    w_bit_end      = (r_clk_cnt == CW'(CLKS_PER_BIT-1));
    w_state_next   = r_state;
    w_clk_cnt_next = w_bit_end ? '0 : r_clk_cnt + CW'(1);
    w_bit_cnt_next = r_bit_cnt;
    w_shreg_next   = r_shreg;
    w_par_next     = r_par;
    w_pop          = 1'b0;
    w_done         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_cnt_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shreg_next = w_fifo_data;
          w_par_next   = (PARITY == PAR_ODD) ? ~^w_fifo_data : ^w_fifo_data;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_bit_cnt_next = '0;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BW'(DATA_BITS-1)) begin
            w_bit_cnt_next = '0;
            w_state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BW'(1);
            w_shreg_next   = r_shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BW'(STOP_BITS-1)) begin
            w_done         = 1'b1;
            w_bit_cnt_next = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_shreg_next = w_fifo_data;
              w_par_next   = (PARITY == PAR_ODD) ? ~^w_fifo_data : ^w_fifo_data;
              w_state_next = ST_START;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + BW'(1);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    case (w_state_next)
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = w_shreg_next[0];
      ST_PARITY: w_txd_next = w_par_next;
      default:   w_txd_next = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_cfg                                             |
// | Description : Self-checking bench for uart_tx_cfg in four frame formats. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valid = 4'b0;
  logic [3:0] ready, txd, busy, done;
  logic [7:0] data0 = '0, data1 = '0, data2 = '0;
  logic [6:0] data3 = '0;
  logic [2:0] lvl0, lvl1, lvl2, lvl3;

  int         checks   = 0;
  int         failures = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  always #5 clock = ~clock;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_8n1 (
    .clock(clock), .reset(reset), .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_data(data0),
    .txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]), .fifo_level(lvl0));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_8e1 (
    .clock(clock), .reset(reset), .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_data(data1),
    .txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]), .fifo_level(lvl1));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_8o1 (
    .clock(clock), .reset(reset), .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_data(data2),
    .txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]), .fifo_level(lvl2));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_7n2 (
    .clock(clock), .reset(reset), .tx_valid(valid[3]), .tx_ready(ready[3]), .tx_data(data3),
    .txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]), .fifo_level(lvl3));

  function automatic logic [11:0] frame8n1(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int inst, input logic [8:0] d);
    case (inst)
      0: data0 = d[7:0];
      1: data1 = d[7:0];
      2: data2 = d[7:0];
      default: data3 = d[6:0];
    endcase
  endtask

  // Single-word push from idle; the expected line frame enters the scoreboard on acceptance.
  task automatic drive(input int inst, input logic [8:0] d, input logic [11:0] exp_frame);
    @(negedge clock);
    check("ready_before_push", 32'(ready[inst]), 32'd1);
    valid[inst] = 1'b1;
    set_data(inst, d);
    @(posedge clock);
    exp_q.push_back(exp_frame);
    #1 valid[inst] = 1'b0;
  endtask

  // Samples txd mid-bit; returns the frame bit vector, tx_done count and cycle position.
  task automatic capture(input int inst, input int nbits, input bit wait_start,
                         output logic [11:0] frame, output int dcnt, output int dpos, output int lat);
    lat = 0;
    if (wait_start) begin
      @(negedge clock);
      while (txd[inst] !== 1'b0 && lat < 2000) begin
        @(negedge clock);
        lat++;
      end
    end else begin
      @(negedge clock);
    end
    frame = '0;
    dcnt  = 0;
    dpos  = 0;
    for (int k = 1; k <= nbits*CPB; k++) begin
      if (k > 1) @(negedge clock);
      if ((k-1) % CPB == CPB/2) frame[(k-1)/CPB] = txd[inst];
      if (done[inst] === 1'b1) begin
        dcnt++;
        dpos = k;
      end
    end
  endtask

  task automatic frame_check(input string name, input int inst, input int nbits,
                             input bit wait_start, input int exp_lat);
    logic [11:0] fr, e;
    int dc, dp, lat;
    capture(inst, nbits, wait_start, fr, dc, dp, lat);
    if (exp_lat >= 0) check({name, "_start_latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard: got a frame 0x%0h, expected none queued", name, fr);
    end else begin
      e = exp_q.pop_front();
      check({name, "_frame"}, 32'(fr), 32'(e));
    end
    check({name, "_done_count"}, 32'(dc), 32'd1);
    check({name, "_done_pos"}, 32'(dp), 32'(nbits*CPB));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   acc[6];
    int   bad;

    vecs[0]  = '{0, 9'h055, 12'h2AA, 10};
    vecs[1]  = '{0, 9'h000, 12'h200, 10};
    vecs[2]  = '{0, 9'h0FF, 12'h3FE, 10};
    vecs[3]  = '{0, 9'h001, 12'h202, 10};
    vecs[4]  = '{1, 9'h007, 12'h60E, 11};
    vecs[5]  = '{1, 9'h000, 12'h400, 11};
    vecs[6]  = '{1, 9'h0A5, 12'h54A, 11};
    vecs[7]  = '{2, 9'h007, 12'h40E, 11};
    vecs[8]  = '{2, 9'h000, 12'h600, 11};
    vecs[9]  = '{2, 9'h080, 12'h500, 11};
    vecs[10] = '{3, 9'h041, 12'h382, 10};
    vecs[11] = '{3, 9'h07F, 12'h3FE, 10};
    vecs[12] = '{3, 9'h000, 12'h300, 10};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_txd", 32'(txd), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(ready), 32'hF);
    check("rst_level", 32'({lvl3, lvl2, lvl1, lvl0}), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_txd", 32'(txd), 32'hF);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].inst, vecs[i].data, vecs[i].frame);
      frame_check($sformatf("vec%0d", i), vecs[i].inst, vecs[i].nbits, 1'b1, 1);
      @(negedge clock);
      check($sformatf("vec%0d_idle_after", i), 32'(busy[vecs[i].inst]), 32'd0);
    end

    // Six words with tx_valid held high into a depth-4 FIFO
    fork
      begin : burst_drv
        logic [7:0] words[6];
        int  idx, edges;
        bit  r, full_seen;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        idx = 0;
        edges = 0;
        full_seen = 1'b0;
        @(negedge clock);
        valid[0] = 1'b1;
        data0    = words[0];
        r        = ready[0];
        while (idx < 6 && edges < 200) begin
          @(posedge clock);
          edges++;
          if (r) begin
            acc[idx] = edges;
            exp_q.push_back(frame8n1(words[idx]));
            idx++;
          end
          #1;
          if (idx < 6) data0 = words[idx];
          else         valid[0] = 1'b0;
          @(negedge clock);
          r = ready[0];
          if (idx == 5 && !full_seen) begin
            full_seen = 1'b1;
            check("burst_ready_full", 32'(ready[0]), 32'd0);
            check("burst_level_full", 32'(lvl0), 32'd4);
          end
        end
        valid[0] = 1'b0;
        check("burst_accepted", 32'(idx), 32'd6);
      end
      begin : burst_mon
        frame_check("burst0", 0, 10, 1'b1, -1);
        for (int k = 1; k < 6; k++) frame_check($sformatf("burst%0d", k), 0, 10, 1'b0, -1);
      end
    join
    check("burst_fifth_edge", 32'(acc[4]), 32'd5);
    check("burst_sixth_edge", 32'(acc[5]), 32'd43);
    @(negedge clock);
    check("burst_idle_after", 32'(busy[0]), 32'd0);

    // Reset during data bit 3 with two words queued
    @(negedge clock);
    valid[0] = 1'b1;
    data0    = 8'h00;
    @(posedge clock); #1 data0 = 8'h11;
    @(posedge clock); #1 data0 = 8'h22;
    @(posedge clock); #1 valid[0] = 1'b0;
    repeat (16) @(negedge clock);
    check("pre_rst_txd", 32'(txd[0]), 32'd0);
    check("pre_rst_level", 32'(lvl0), 32'd2);
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd[0]), 32'd1);
    check("mid_rst_level", 32'(lvl0), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_ready", 32'(ready[0]), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);

    // Push landing on the tx_done edge with the FIFO empty
    drive(0, 9'h03C, frame8n1(8'h3C));
    frame_check("edge_a", 0, 10, 1'b1, 1);
    valid[0] = 1'b1;
    data0    = 8'hC3;
    @(posedge clock);
    exp_q.push_back(frame8n1(8'hC3));
    #1 valid[0] = 1'b0;
    @(negedge clock);
    check("edge_gap_txd", 32'(txd[0]), 32'd1);
    check("edge_gap_level", 32'(lvl0), 32'd1);
    frame_check("edge_b", 0, 10, 1'b0, -1);
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("edge_no_dup", 32'(bad), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
